// File: rtl/adder_acc_pkg.sv
// Shared FSM encodings and sizing constants for adder_accumulator.
// Used by rtl/adder_accumulator.sv.
package adder_acc_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 8;  // holds a frame length of up to 255 samples

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_carry_adder.sv
// Plain ripple-carry adder.
// result_o[WIDTH] is the carry out of the most significant bit.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] term1_i,
  input  logic [WIDTH-1:0] term2_i,
  output logic [WIDTH:0]   result_o
);

  always_comb begin : rca
    logic carry;
    carry    = 1'b0;
    result_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      result_o[i] = term1_i[i] ^ term2_i[i] ^ carry;
      carry       = (term1_i[i] & term2_i[i]) | (carry & (term1_i[i] ^ term2_i[i]));
    end
    result_o[WIDTH] = carry;
  end

endmodule

// File: rtl/adder_accumulator.sv
// Sums COUNT unsigned samples per frame and presents the sum with a sticky overflow flag.
// Define ADDER_ACC_SAT_EN to saturate on overflow; by default the sum wraps.
module adder_accumulator
  import adder_acc_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_sample,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic                 o_overflow
);

  localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH:0]   add_res;
  logic                 carry;
  logic                 accept;

  assign sample_ext = ACC_WIDTH'(i_sample);

  ripple_carry_adder #(.WIDTH(ACC_WIDTH)) u_adder (
    .term1_i  (acc_q),
    .term2_i  (sample_ext),
    .result_o (add_res)
  );

  assign carry   = add_res[ACC_WIDTH];
  assign o_ready = (state_q != ST_OUTPUT);
  assign accept  = i_valid & o_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = sample_ext;
          cnt_d   = 8'd1;
          ovf_d   = 1'b0;
          state_d = (COUNT_C == 8'd1) ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          ovf_d = ovf_q | carry;
`ifdef ADDER_ACC_SAT_EN
          // Once saturated, stay pinned at all-ones until the next frame.
          acc_d = (carry || ovf_q) ? '1 : add_res[ACC_WIDTH-1:0];
`else
          acc_d = add_res[ACC_WIDTH-1:0];
`endif
          if (cnt_d == COUNT_C) state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_valid    = (state_q == ST_OUTPUT);
  assign o_sum      = acc_q;
  assign o_overflow = ovf_q;

endmodule

// File: doc/adder_accumulator.md
ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of each input sample.
REQ-002 SHALL have parameter COUNT, default 4: samples summed per frame, legal range 1..255.
REQ-003 SHALL have parameter ACC_WIDTH, default 6: accumulator and sum width, legal when ACC_WIDTH >= WIDTH.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1 bit: input sample valid.
REQ-007 SHALL have port o_ready, output, 1 bit: block can accept a sample.
REQ-008 SHALL have port i_sample, input, WIDTH bits: unsigned sample.
REQ-009 SHALL have port o_valid, output, 1 bit: frame sum valid.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts the sum.
REQ-011 SHALL have port o_sum, output, ACC_WIDTH bits: frame sum.
REQ-012 SHALL have port o_overflow, output, 1 bit: an overflow occurred in this frame; qualified by o_valid.

Function
REQ-013 SHALL use a three-state FSM: IDLE, ACCUM, OUTPUT.
REQ-014 SHALL treat a sample as accepted on a rising edge with i_valid=1 and o_ready=1; o_ready=1 in IDLE and ACCUM, 0 in OUTPUT.
REQ-015 SHALL, on an accept in IDLE, load acc = zero-extended i_sample, set cnt=1, clear the overflow flag, and go to ACCUM.
REQ-016 SHALL, on an accept in ACCUM, set acc = acc + zero-extended i_sample (computed by the adder sub-module), cnt = cnt+1.
REQ-017 SHALL go to OUTPUT on the edge that accepts the COUNT-th sample; with COUNT=1 that is IDLE -> OUTPUT directly.
REQ-018 SHALL assert o_valid in the cycle after the COUNT-th accept (latency 1) and hold o_valid, o_sum and o_overflow stable until i_ready=1.
REQ-019 SHALL, on o_valid=1 and i_ready=1, return to IDLE, with o_valid=0 from the next cycle.
REQ-020 SHALL not overlap frames: no sample is accepted in the handshake cycle.
REQ-021 SHALL set overflow when the adder carry-out (result bit ACC_WIDTH) is 1 on any accepted add; the flag is sticky until the next frame start.
REQ-022 SHALL leave state unchanged during i_valid=0 gaps, in any number.
REQ-023 SHALL drive o_sum = acc; o_sum is don't-care while o_valid=0.

Reset
REQ-024 SHALL, when i_rst=1 at an edge, set state=IDLE, acc=0, cnt=0, overflow flag=0, o_valid=0; o_ready=1 from the following cycle.
REQ-025 SHALL take reset priority over any handshake, and a mid-frame reset SHALL discard the partial sum.

Configuration
REQ-026 SHALL, with ADDER_ACC_SAT_EN defined, saturate acc at all-ones on carry-out and hold that value for the rest of the frame, with o_overflow=1.
REQ-027 SHALL, without ADDER_ACC_SAT_EN, wrap acc modulo 2^ACC_WIDTH, with o_overflow=1.

Structure
REQ-028 SHALL place the FSM state encodings (IDLE=0, ACCUM=1, OUTPUT=2) and the state width constant in shared package adder_acc_pkg.
REQ-029 SHALL instantiate exactly one sub-module, ripple_carry_adder #(.WIDTH(ACC_WIDTH)), with term1=acc, term2=zero-extended i_sample, and result bit ACC_WIDTH used as carry.

Verification
REQ-030 SHALL cover: defaults, samples 1,2,3,4 back-to-back -> o_valid one cycle after 4th accept, o_sum=10, o_overflow=0.
REQ-031 SHALL cover: ACC_WIDTH=5, samples 15,15,15,15 -> o_overflow=1, o_sum=28 without ADDER_ACC_SAT_EN and 31 with it.
REQ-032 SHALL cover: i_ready held 0 for 5 cycles in OUTPUT -> o_sum/o_overflow stable, o_ready=0, i_valid ignored; handshake -> IDLE next cycle.
REQ-033 SHALL cover: i_rst pulsed after 2 samples of 7,7, then frame 1,1,1,1 -> o_sum=4, o_overflow=0.
REQ-034 SHALL cover: COUNT=1, samples 9 then 5 with i_ready=1 -> sums 9 then 5, no sample accepted in the handshake cycle.
REQ-035 SHALL cover: i_valid toggled with random gaps across samples 2,4,6,8 -> o_sum=20.
